// File: rtl/decode_38.sv
// Registered 3-to-8 one-hot decoder with selectable output polarity and a sticky valid flag.
// Each output bit is its own registered lane, so no combinational path runs from a/en to y.

module decode_38_lane #(
  parameter int unsigned LANE       = 0,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [2:0] a_i,
  output logic       y_o
);
  logic y_q, y_d;

  always_comb begin
    y_d = y_q;
    if (en_i) y_d = (a_i == 3'(LANE)) ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (rst) y_q <= ACTIVE_LOW;
    else     y_q <= y_d;
  end

  assign y_o = y_q;
endmodule

module decode_38 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] a,
  output logic [7:0] y,
  output logic       vld
);
  localparam int unsigned NUM_LANES = 8;

  logic vld_q, vld_d;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    decode_38_lane #(
      .LANE      (k),
      .ACTIVE_LOW(OUT_ACTIVE_LOW)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en_i(en),
      .a_i (a),
      .y_o (y[k])
    );
  end

  // Sticky once any enabled edge has loaded a decode; only reset clears it.
  always_comb begin
    vld_d = vld_q | en;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end

  assign vld = vld_q;
endmodule

// File: tb/tb_decode_38.sv
// Bench for decode_38: both polarities driven in lockstep, compared each cycle
// against a behavioural model (shift-based one-hot, held on en=0, cleared by reset).

module tb_decode_38;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [2:0] a;
  logic [7:0] y_hi, y_lo;
  logic       vld_hi, vld_lo;

  int passed = 0;
  int total  = 0;

  // model state: active-high pattern and valid flag
  logic [7:0] m_y;
  logic       m_vld;
  logic [2:0] a_prev;
  bit         m_known;

  always #5 clk = ~clk;

  decode_38 #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .en(en), .a(a), .y(y_hi), .vld(vld_hi)
  );
  decode_38 #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .en(en), .a(a), .y(y_lo), .vld(vld_lo)
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b, expected %b", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk8({tag, " y_hi"}, y_hi, m_y);
    chk8({tag, " y_lo"}, y_lo, ~m_y);
    chk1({tag, " vld_hi"}, vld_hi, m_vld);
    chk1({tag, " vld_lo"}, vld_lo, m_vld);
    if (m_vld) begin
      chk8({tag, " onehot_hi"}, 8'($countones(y_hi)), 8'd1);
      chk8({tag, " onehot_lo"}, 8'($countones(~y_lo)), 8'd1);
      chk8({tag, " a_prev"}, y_hi, 8'(1) << a_prev);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic tick(input logic r, input logic e, input logic [2:0] av,
                      input string tag, input bit do_chk);
    rst = r; en = e; a = av;
    @(posedge clk);
    if (r) begin
      m_y = 8'h00; m_vld = 1'b0; m_known = 1'b1;
    end else if (e) begin
      m_y = 8'h00;
      m_y[av] = 1'b1;
      m_vld = 1'b1;
      a_prev = av;
      m_known = 1'b1;
    end
    #1;
    if (do_chk && m_known) check_all(tag);
  endtask

  initial begin
    logic       r, e;
    logic [2:0] av;
    m_y = 8'h00; m_vld = 1'b0; a_prev = 3'd0; m_known = 1'b0;
    rst = 1'b0; en = 1'b0; a = 3'd0;
    @(negedge clk);

    // reset for 2 cycles with en=1 and a=5: reset wins
    tick(1'b1, 1'b1, 3'd5, "reset0", 1'b1);
    tick(1'b1, 1'b1, 3'd5, "reset1", 1'b1);

    // full sweep, back-to-back codes
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, 3'(k), "sweep", 1'b1);
    chk8("sweep_last", y_hi, 8'h80);

    // hold with en=0 while a changes
    tick(1'b0, 1'b1, 3'd2, "hold_load", 1'b1);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 3'd6, "hold", 1'b1);
    chk8("hold_const", y_hi, 8'h04);

    // repeated identical code
    tick(1'b0, 1'b1, 3'd3, "repeat0", 1'b1);
    chk8("polarity_f7", y_lo, 8'hF7);
    tick(1'b0, 1'b1, 3'd3, "repeat1", 1'b1);

    // reset mid-operation, then recovery on the next edge
    tick(1'b0, 1'b1, 3'd7, "mid_load", 1'b1);
    tick(1'b1, 1'b1, 3'd1, "mid_rst", 1'b1);
    chk8("mid_rst_lo", y_lo, 8'hFF);
    tick(1'b0, 1'b1, 3'd1, "mid_recover", 1'b1);
    chk8("mid_recover_y", y_hi, 8'h02);

    // en=0 right after reset keeps vld low
    tick(1'b1, 1'b0, 3'd0, "rst_noen", 1'b1);
    tick(1'b0, 1'b0, 3'd4, "idle_after_rst", 1'b1);
    tick(1'b0, 1'b1, 3'd4, "first_en", 1'b1);

    // unknown code: content undefined, but the next valid code must recover
    rst = 1'b0; en = 1'b1; a = 3'bxxx;
    @(posedge clk);
    m_known = 1'b0;
    #1;
    tick(1'b0, 1'b1, 3'd6, "x_recover", 1'b1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      av = 3'($urandom_range(0, 7));
      tick(r, e, av, "rand", 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
